// File: rtl/bcd_up_cnt.sv
// Cascadable BCD up-counter with synchronous load, sticky invalid-load flag and carry outputs.
// Optional compare-match pulse output enabled by defining BCD_UP_CNT_MATCH_EN.
module bcd_up_cnt #(
  parameter int unsigned DIGITS = 2
) (
  input  logic                clk,
  input  logic                mr,
  input  logic                en,
  input  logic                ci,
  input  logic                ld,
  input  logic [4*DIGITS-1:0] d,
`ifdef BCD_UP_CNT_MATCH_EN
  input  logic [4*DIGITS-1:0] cmp,
  output logic                match,
`endif
  output logic [4*DIGITS-1:0] q,
  output logic                co,
  output logic                rco,
  output logic                err
);

  localparam int unsigned W = 4 * DIGITS;

  logic [W-1:0] q_d, q_q;
  logic         err_d, err_q;
  logic [W-1:0] cnt_val;
  logic [W-1:0] ld_val;
  logic         ld_bad;
  logic         carry;
  logic         all_nine;

  // Per-digit increment chain, load sanitising and terminal-count detect.
  always_comb begin
    cnt_val  = '0;
    ld_val   = '0;
    ld_bad   = 1'b0;
    carry    = en & ci;
    all_nine = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (q_q[4*k +: 4] != 4'd9) all_nine = 1'b0;
      if (!carry) begin
        cnt_val[4*k +: 4] = q_q[4*k +: 4];
      end else if (q_q[4*k +: 4] >= 4'd9) begin
        cnt_val[4*k +: 4] = 4'd0;
      end else begin
        cnt_val[4*k +: 4] = q_q[4*k +: 4] + 4'd1;
        carry             = 1'b0;
      end
      if (d[4*k +: 4] > 4'd9) begin
        ld_val[4*k +: 4] = 4'd0;
        ld_bad           = 1'b1;
      end else begin
        ld_val[4*k +: 4] = d[4*k +: 4];
      end
    end
  end

  always_comb begin
    q_d   = cnt_val;
    err_d = err_q;
    if (ld) begin
      q_d   = ld_val;
      err_d = err_q | ld_bad;
    end
  end

  always_ff @(posedge clk or posedge mr) begin
    if (mr) begin
      q_q   <= '0;
      err_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      err_q <= err_d;
    end
  end

  assign q   = q_q;
  assign err = err_q;
  // Gated by mr so the carry chain stays quiet for the whole reset interval.
  assign co  = all_nine & ~mr;
  assign rco = co & en & ci;

`ifdef BCD_UP_CNT_MATCH_EN
  logic [W-1:0] q_prev_q;
  logic         match_d, match_q;

  // Pulse only on arrival at cmp; a held value equals its predecessor.
  always_comb begin
    match_d = (q_q == cmp) && (q_q != q_prev_q);
  end

  always_ff @(posedge clk or posedge mr) begin
    if (mr) begin
      q_prev_q <= '0;
      match_q  <= 1'b0;
    end else begin
      q_prev_q <= q_q;
      match_q  <= match_d;
    end
  end

  assign match = match_q;
`endif

endmodule

// File: tb/tb_bcd_up_cnt.sv
// Scoreboard bench for bcd_up_cnt (DIGITS=2): a decimal reference model pushes expected
// q/err (and match when BCD_UP_CNT_MATCH_EN is defined) per edge; each test task pops and checks.
module tb_bcd_up_cnt;

  localparam int unsigned DIGITS = 2;
  localparam int unsigned W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         mr  = 1'b1;
  logic         en  = 1'b0;
  logic         ci  = 1'b0;
  logic         ld  = 1'b0;
  logic [W-1:0] d   = '0;
  logic [W-1:0] q;
  logic         co, rco, err;
`ifdef BCD_UP_CNT_MATCH_EN
  logic [W-1:0] cmp = '0;
  logic         match;
`endif

  bcd_up_cnt #(.DIGITS(DIGITS)) dut (
    .clk  (clk),
    .mr   (mr),
    .en   (en),
    .ci   (ci),
    .ld   (ld),
    .d    (d),
`ifdef BCD_UP_CNT_MATCH_EN
    .cmp  (cmp),
    .match(match),
`endif
    .q    (q),
    .co   (co),
    .rco  (rco),
    .err  (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: decimal value plus sticky error.
  int       mval  = 0;
  int       mprev = 0;
  bit       merr  = 1'b0;
  logic [W-1:0] exp_q_fifo[$];
  logic         exp_err_fifo[$];
  logic         exp_match_fifo[$];

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    r[3:0] = 4'(v % 10);
    r[7:4] = 4'(v / 10);
    return r;
  endfunction

  task automatic model_reset();
    mval  = 0;
    mprev = 0;
    merr  = 1'b0;
  endtask

  // Drive one edge's worth of stimulus, advance the model, push expectations.
  task automatic cycle(input logic i_ld, input logic i_en, input logic i_ci, input logic [W-1:0] i_d);
    int lo, hi;
    logic m;
    ld = i_ld; en = i_en; ci = i_ci; d = i_d;
`ifdef BCD_UP_CNT_MATCH_EN
    m = (to_bcd(mval) == cmp) && (mval != mprev);
`else
    m = 1'b0;
`endif
    mprev = mval;
    if (i_ld) begin
      lo = int'(i_d[3:0]);
      hi = int'(i_d[7:4]);
      if (lo > 9) begin lo = 0; merr = 1'b1; end
      if (hi > 9) begin hi = 0; merr = 1'b1; end
      mval = hi * 10 + lo;
    end else if (i_en && i_ci) begin
      mval = (mval + 1) % 100;
    end
    exp_q_fifo.push_back(to_bcd(mval));
    exp_err_fifo.push_back(merr);
    exp_match_fifo.push_back(m);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [W-1:0] eq;
    mr = 1'b1; en = 1'b1; ci = 1'b1; ld = 1'b1; d = 8'h55;
    #2;
    n_tests++;
    if (q !== 8'h00) begin n_fail++; $display("FAIL reset_q: got %h expected %h", q, 8'h00); end
    n_tests++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected %b", err, 1'b0); end
    n_tests++;
    if (rco !== 1'b0 || co !== 1'b0) begin n_fail++; $display("FAIL reset_carry: got co=%b rco=%b expected 0 0", co, rco); end
    @(posedge clk); #1;
    n_tests++;
    if (q !== 8'h00) begin n_fail++; $display("FAIL reset_hold_q: got %h expected %h", q, 8'h00); end
    @(negedge clk);
    ld = 1'b0; en = 1'b0; ci = 1'b0;
    mr = 1'b0;
    model_reset();
    eq = '0;
  endtask

  task automatic test_count();
    logic [W-1:0] eq;
    logic         ee;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 8'h00);
      eq = exp_q_fifo.pop_front();
      ee = exp_err_fifo.pop_front();
      void'(exp_match_fifo.pop_front());
      n_tests++;
      if (q !== eq) begin n_fail++; $display("FAIL count_q[%0d]: got %h expected %h", i, q, eq); end
    end
    n_tests++;
    if (q !== 8'h12) begin n_fail++; $display("FAIL count_final: got %h expected %h", q, 8'h12); end
    n_tests++;
    if (err !== ee) begin n_fail++; $display("FAIL count_err: got %b expected %b", err, ee); end
  endtask

  task automatic test_wrap();
    logic [W-1:0] eq;
    cycle(1'b1, 1'b0, 1'b0, 8'h98);
    eq = exp_q_fifo.pop_front(); void'(exp_err_fifo.pop_front()); void'(exp_match_fifo.pop_front());
    n_tests++;
    if (q !== eq) begin n_fail++; $display("FAIL wrap_load: got %h expected %h", q, eq); end
    cycle(1'b0, 1'b1, 1'b1, 8'h00);
    eq = exp_q_fifo.pop_front(); void'(exp_err_fifo.pop_front()); void'(exp_match_fifo.pop_front());
    n_tests++;
    if (q !== eq) begin n_fail++; $display("FAIL wrap_99: got %h expected %h", q, eq); end
    n_tests++;
    if (co !== (mval == 99) || rco !== (mval == 99)) begin
      n_fail++; $display("FAIL wrap_co_rco: got co=%b rco=%b expected %b %b", co, rco, mval == 99, mval == 99);
    end
    ci = 1'b0; #1;
    n_tests++;
    if (rco !== 1'b0 || co !== 1'b1) begin n_fail++; $display("FAIL wrap_rco_ci0: got co=%b rco=%b expected 1 0", co, rco); end
    cycle(1'b0, 1'b1, 1'b1, 8'h00);
    eq = exp_q_fifo.pop_front(); void'(exp_err_fifo.pop_front()); void'(exp_match_fifo.pop_front());
    n_tests++;
    if (q !== eq || q !== 8'h00) begin n_fail++; $display("FAIL wrap_00: got %h expected %h", q, eq); end
    n_tests++;
    if (co !== 1'b0) begin n_fail++; $display("FAIL wrap_co_clear: got %b expected %b", co, 1'b0); end
  endtask

  task automatic test_invalid_load();
    logic [W-1:0] eq;
    logic         ee;
    cycle(1'b1, 1'b0, 1'b0, 8'hA7);
    eq = exp_q_fifo.pop_front(); ee = exp_err_fifo.pop_front(); void'(exp_match_fifo.pop_front());
    n_tests++;
    if (q !== eq) begin n_fail++; $display("FAIL inv_load_q: got %h expected %h", q, eq); end
    n_tests++;
    if (err !== ee) begin n_fail++; $display("FAIL inv_load_err: got %b expected %b", err, ee); end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 8'h00);
      eq = exp_q_fifo.pop_front(); ee = exp_err_fifo.pop_front(); void'(exp_match_fifo.pop_front());
      n_tests++;
      if (q !== eq || err !== ee) begin
        n_fail++; $display("FAIL inv_count[%0d]: got q=%h err=%b expected q=%h err=%b", i, q, err, eq, ee);
      end
    end
    n_tests++;
    if (q !== 8'h10) begin n_fail++; $display("FAIL inv_final: got %h expected %h", q, 8'h10); end
    cycle(1'b1, 1'b0, 1'b0, 8'h23);
    eq = exp_q_fifo.pop_front(); ee = exp_err_fifo.pop_front(); void'(exp_match_fifo.pop_front());
    n_tests++;
    if (q !== eq || err !== ee) begin
      n_fail++; $display("FAIL inv_sticky: got q=%h err=%b expected q=%h err=%b", q, err, eq, ee);
    end
  endtask

  task automatic test_gating();
    logic [W-1:0] eq;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, (i % 2) == 1, (i % 2) == 0, 8'h00);
      eq = exp_q_fifo.pop_front(); void'(exp_err_fifo.pop_front()); void'(exp_match_fifo.pop_front());
      n_tests++;
      if (q !== eq) begin n_fail++; $display("FAIL gate_hold[%0d]: got %h expected %h", i, q, eq); end
    end
    cycle(1'b1, 1'b1, 1'b1, 8'h45);
    eq = exp_q_fifo.pop_front(); void'(exp_err_fifo.pop_front()); void'(exp_match_fifo.pop_front());
    n_tests++;
    if (q !== eq || q !== 8'h45) begin n_fail++; $display("FAIL gate_ld_priority: got %h expected %h", q, eq); end
  endtask

  task automatic test_async_reset();
    logic [W-1:0] eq;
    logic         ee;
    cycle(1'b1, 1'b0, 1'b0, 8'h37);
    eq = exp_q_fifo.pop_front(); void'(exp_err_fifo.pop_front()); void'(exp_match_fifo.pop_front());
    n_tests++;
    if (q !== eq) begin n_fail++; $display("FAIL async_pre: got %h expected %h", q, eq); end
    #2;
    mr = 1'b1; en = 1'b1; ci = 1'b1; ld = 1'b1; d = 8'h99;
    #1;
    n_tests++;
    if (q !== 8'h00 || err !== 1'b0) begin n_fail++; $display("FAIL async_clear: got q=%h err=%b expected 00 0", q, err); end
    n_tests++;
    if (rco !== 1'b0) begin n_fail++; $display("FAIL async_rco: got %b expected %b", rco, 1'b0); end
    @(posedge clk); #1;
    n_tests++;
    if (q !== 8'h00 || co !== 1'b0) begin n_fail++; $display("FAIL async_ignore_ld: got q=%h co=%b expected 00 0", q, co); end
    @(negedge clk);
    mr = 1'b0;
    model_reset();
    cycle(1'b1, 1'b0, 1'b0, 8'h21);
    eq = exp_q_fifo.pop_front(); ee = exp_err_fifo.pop_front(); void'(exp_match_fifo.pop_front());
    n_tests++;
    if (q !== eq || err !== ee) begin n_fail++; $display("FAIL async_first_edge: got q=%h err=%b expected q=%h err=%b", q, err, eq, ee); end
    cycle(1'b0, 1'b1, 1'b1, 8'h00);
    eq = exp_q_fifo.pop_front(); void'(exp_err_fifo.pop_front()); void'(exp_match_fifo.pop_front());
    n_tests++;
    if (q !== eq) begin n_fail++; $display("FAIL async_count: got %h expected %h", q, eq); end
  endtask

`ifdef BCD_UP_CNT_MATCH_EN
  task automatic test_match();
    logic [W-1:0] eq;
    logic         em;
    int           pulses;
    cmp = 8'h05;
    mr = 1'b1; #1;
    n_tests++;
    if (match !== 1'b0) begin n_fail++; $display("FAIL match_reset: got %b expected %b", match, 1'b0); end
    @(negedge clk);
    mr = 1'b0;
    model_reset();
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, i < 5, 1'b1, 8'h00);
      eq = exp_q_fifo.pop_front(); void'(exp_err_fifo.pop_front()); em = exp_match_fifo.pop_front();
      if (match === 1'b1) pulses++;
      n_tests++;
      if (q !== eq || match !== em) begin
        n_fail++; $display("FAIL match_cycle[%0d]: got q=%h match=%b expected q=%h match=%b", i, q, match, eq, em);
      end
    end
    n_tests++;
    if (pulses != 1) begin n_fail++; $display("FAIL match_pulse_count: got %0d expected %0d", pulses, 1); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_count();
    test_wrap();
    test_invalid_load();
    test_gating();
    test_async_reset();
`ifdef BCD_UP_CNT_MATCH_EN
    test_match();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_up_cnt.md
BCD_UP_CNT -- requirements
Module: bcd_up_cnt

Interface
REQ-001 Parameter DIGITS, default 2: number of cascaded BCD decades, legal range 1..4.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 mr  input  1  reset, asynchronous, active-high.
REQ-004 en  input  1  count enable; high enables counting, low holds.
REQ-005 ci  input  1  cascade carry-in; the counter advances only when en=1 and ci=1.
REQ-006 ld  input  1  synchronous parallel load, priority over counting.
REQ-007 d  input  4*DIGITS  load value, digit k at bits [4k+3:4k], least significant digit at k=0.
REQ-008 q  output  4*DIGITS  registered BCD count, same digit layout as d.
REQ-009 co  output  1  terminal count: high when every digit of q is 9.
REQ-010 rco  output  1  ripple carry for cascading: co AND en AND ci.
REQ-011 err  output  1  sticky flag: a load contained an invalid BCD digit.

Function
REQ-012 Counting SHALL follow 0..(10^DIGITS - 1) in BCD, incrementing by 1 per enabled edge.
REQ-013 Digit k SHALL increment when en=1, ci=1 and all lower digits equal 9; a digit at 9 SHALL wrap to 0 in the same edge.
REQ-014 At all-nines with en=1 and ci=1, q SHALL wrap to all zeros on the next edge.
REQ-015 Edge priority SHALL be: mr, then ld, then count (en AND ci), then hold.
REQ-016 ld=1 SHALL load d on the next edge regardless of en and ci; an invalid digit (>9) SHALL be stored as 0 and SHALL set err.
REQ-017 Once set, err SHALL remain high until mr; valid loads and counting SHALL NOT clear it.
REQ-018 When en=0 or ci=0, and ld=0, q SHALL hold.
REQ-019 co and rco SHALL be combinational from q, en and ci, with zero latency and no registered delay.
REQ-020 q SHALL never hold a digit value above 9.
REQ-021 Cascading two instances, with the upper instance's ci tied to the lower instance's rco, SHALL yield a contiguous count across both instances.

Reset
REQ-022 mr=1 SHALL immediately force q=0 and err=0, independent of clk.
REQ-023 While mr is high, co SHALL be 0, rco SHALL be 0, and ld and count SHALL be ignored.
REQ-024 Reset SHALL be legal mid-count and mid-load; the first edge after mr deasserts SHALL act on ld, en and ci normally.

Configuration
REQ-025 Macro BCD_UP_CNT_MATCH_EN, when defined, SHALL add input cmp (4*DIGITS bits) and output match (1 bit).
REQ-026 With the macro defined, match SHALL be a registered one-cycle pulse, asserted the edge after q transitions to a value equal to cmp by counting or by load.
REQ-027 With the macro defined, match SHALL NOT re-pulse while q holds at cmp, and SHALL reset to 0.
REQ-028 Without the macro, cmp, match and their logic SHALL be absent; all other behaviour SHALL be identical.

Verification (DIGITS=2)
REQ-029 Reset and count: pulse mr, then en=1, ci=1 for 12 edges -> q=0x12; err=0.
REQ-030 Decade carry and wrap: load 0x98, count 2 edges -> q=0x00; co=1 and rco=1 during q=0x99.
REQ-031 Invalid load: load 0xA7 -> q=0x07 and err=1; after 3 counts, q=0x10 and err is still 1.
REQ-032 Gating and priority: en=1, ci=0 holds q; ld=1 with en=1 and d=0x45 -> q=0x45, not 0x46.
REQ-033 Async reset: assert mr between edges at q=0x37 -> q=0 before the next edge; rco=0 while mr is high.
REQ-034 Match (macro defined): cmp=0x05, count from 0 -> match is high exactly one cycle after q=0x05; en=0 holding at 0x05 gives no further pulse.
